// File: rtl/usb_token_decoder.sv
// USB token decoder: validates PID/check nibble, runs CRC5 over the token field and
// strobes accepted OUT/IN/SETUP/SOF tokens (or a malformed-token error) for one cycle.
module usb_token_decoder #(
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [6:0]  dev_addr,
    output logic        tok_valid,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic [10:0] tok_frame,
    output logic        tok_err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {IDLE, PID, B1, B2, TAIL, ERR, DROP} state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [4:0] CRC_INIT  = 5'b11111;
    localparam logic [4:0] CRC_GOOD  = 5'b01100;

    state_t     state, state_nx;
    logic [3:0] pid_q, pid_nx;
    logic [6:0] addr_q, addr_nx;
    logic [3:0] endp_q, endp_nx;
    logic [4:0] crc_q, crc_nx;
    logic       valid_nx, err_nx;
    logic [1:0] code_nx;

    // Eight serial CRC5 steps, LSB of the byte first as it appears on the wire.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c_in, input logic [7:0] d);
        logic [4:0] c;
        logic       fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    function automatic logic is_token(input logic [3:0] p);
        return (p == PID_OUT) || (p == PID_IN) || (p == PID_SETUP) || (p == PID_SOF);
    endfunction

    always_comb begin
        state_nx = state;
        pid_nx   = pid_q;
        addr_nx  = addr_q;
        endp_nx  = endp_q;
        crc_nx   = crc_q;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        code_nx  = 2'd0;
        case (state)
            // IDLE also takes the PID byte so a packet starting right after a strobe is not lost.
            IDLE, PID: begin
                crc_nx = CRC_INIT;
                if (!rx_active) begin
                    state_nx = IDLE;
                end else if (rx_valid) begin
                    if (rx_data[7:4] != ~rx_data[3:0]) begin
                        err_nx   = 1'b1;
                        code_nx  = 2'd1;
                        state_nx = ERR;
                    end else if (is_token(rx_data[3:0])) begin
                        pid_nx   = rx_data[3:0];
                        state_nx = B1;
                    end else begin
                        state_nx = DROP;
                    end
                end else begin
                    state_nx = PID;
                end
            end
            B1: begin
                if (!rx_active) begin
                    err_nx   = 1'b1;
                    code_nx  = 2'd3;
                    state_nx = IDLE;
                end else if (rx_valid) begin
                    addr_nx  = rx_data[6:0];
                    endp_nx  = {endp_q[3:1], rx_data[7]};
                    crc_nx   = crc5_byte(crc_q, rx_data);
                    state_nx = B2;
                end
            end
            B2: begin
                if (!rx_active) begin
                    err_nx   = 1'b1;
                    code_nx  = 2'd3;
                    state_nx = IDLE;
                end else if (rx_valid) begin
                    endp_nx  = {rx_data[2:0], endp_q[0]};
                    crc_nx   = crc5_byte(crc_q, rx_data);
                    state_nx = TAIL;
                end
            end
            // End-of-packet verdicts return straight to IDLE so back-to-back packets need no gap.
            TAIL: begin
                if (!rx_active) begin
                    state_nx = IDLE;
                    if (CHECK_CRC && (crc_q != CRC_GOOD)) begin
                        err_nx  = 1'b1;
                        code_nx = 2'd2;
                    end else if ((pid_q == PID_SOF) || (addr_q == dev_addr)) begin
                        valid_nx = 1'b1;
                    end
                end else if (rx_valid) begin
                    err_nx   = 1'b1;
                    code_nx  = 2'd3;
                    state_nx = ERR;
                end
            end
            ERR, DROP: begin
                if (!rx_active) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pid_q     <= 4'd0;
            addr_q    <= 7'd0;
            endp_q    <= 4'd0;
            crc_q     <= CRC_INIT;
            tok_valid <= 1'b0;
            tok_err   <= 1'b0;
            err_code  <= 2'd0;
            tok_pid   <= 4'd0;
            tok_addr  <= 7'd0;
            tok_endp  <= 4'd0;
            tok_frame <= 11'd0;
        end else begin
            state     <= state_nx;
            pid_q     <= pid_nx;
            addr_q    <= addr_nx;
            endp_q    <= endp_nx;
            crc_q     <= crc_nx;
            tok_valid <= valid_nx;
            tok_err   <= err_nx;
            if (err_nx) err_code <= code_nx;
            if (valid_nx) begin
                tok_pid   <= pid_q;
                tok_addr  <= addr_q;
                tok_endp  <= endp_q;
                tok_frame <= {endp_q, addr_q};
            end
        end
    end

endmodule

// File: tb/tb_usb_token_decoder.sv
// Directed bench for usb_token_decoder: two instances (CRC checked / CRC ignored)
// share the receive stream; strobes are counted on the falling clock edge.
module tb_usb_token_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_active, rx_valid;
    logic [7:0]  rx_data;
    logic [6:0]  dev_addr;

    logic        tok_valid, tok_err;
    logic [3:0]  tok_pid, tok_endp;
    logic [6:0]  tok_addr;
    logic [10:0] tok_frame;
    logic [1:0]  err_code;

    logic        nc_valid, nc_err;
    logic [3:0]  nc_pid, nc_endp;
    logic [6:0]  nc_addr;
    logic [10:0] nc_frame;
    logic [1:0]  nc_code;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int nc_valid_cnt = 0;

    logic [7:0] pkt[$];

    always #5 clk = ~clk;

    usb_token_decoder #(.CHECK_CRC(1'b1)) dut (
        .clk(clk), .reset(reset), .rx_active(rx_active), .rx_valid(rx_valid),
        .rx_data(rx_data), .dev_addr(dev_addr), .tok_valid(tok_valid), .tok_pid(tok_pid),
        .tok_addr(tok_addr), .tok_endp(tok_endp), .tok_frame(tok_frame),
        .tok_err(tok_err), .err_code(err_code)
    );

    usb_token_decoder #(.CHECK_CRC(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .rx_active(rx_active), .rx_valid(rx_valid),
        .rx_data(rx_data), .dev_addr(dev_addr), .tok_valid(nc_valid), .tok_pid(nc_pid),
        .tok_addr(nc_addr), .tok_endp(nc_endp), .tok_frame(nc_frame),
        .tok_err(nc_err), .err_code(nc_code)
    );

    always @(negedge clk) begin
        if (tok_valid === 1'b1) valid_cnt++;
        if (tok_err === 1'b1)   err_cnt++;
        if (nc_valid === 1'b1)  nc_valid_cnt++;
    end

    // Byte 2 of a token: endp[3:1] plus the inverted CRC5 of {endp,addr}, MSB of the CRC first on the wire.
    function automatic logic [7:0] token_b2(input logic [6:0] addr, input logic [3:0] endp);
        logic [10:0] d;
        logic [4:0]  c;
        logic        fb;
        d = {endp, addr};
        c = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        c = ~c;
        return {c[0], c[1], c[2], c[3], c[4], endp[3:1]};
    endfunction

    // Sends pkt as one packet, drops rx_active, and returns 1ns after the edge that sees the fall.
    task automatic apply_stimulus();
        rx_active = 1'b1;
        foreach (pkt[i]) begin
            rx_valid = 1'b1;
            rx_data  = pkt[i];
            @(posedge clk); #1;
        end
        rx_valid  = 1'b0;
        rx_active = 1'b0;
        rx_data   = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int v0, e0, n0;
        reset     = 1'b1;
        rx_active = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        dev_addr  = 7'h05;
        idle_cycles(3);
        check_output("reset_valid", tok_valid, 0);
        check_output("reset_err", tok_err, 0);
        check_output("reset_code", err_code, 0);
        check_output("reset_pid", tok_pid, 0);
        check_output("reset_frame", tok_frame, 0);
        reset = 1'b0;
        idle_cycles(2);

        // OUT to addr 5 endp 2
        v0 = valid_cnt; e0 = err_cnt;
        pkt = '{8'hE1, 8'h05, token_b2(7'h05, 4'h2)};
        apply_stimulus();
        check_output("out_valid", tok_valid, 1);
        check_output("out_pid", tok_pid, 4'h1);
        check_output("out_addr", tok_addr, 7'h05);
        check_output("out_endp", tok_endp, 4'h2);
        check_output("out_frame", tok_frame, 11'h105);
        idle_cycles(1);
        check_output("out_width", tok_valid, 0);
        check_output("out_count", valid_cnt - v0, 1);
        check_output("out_no_err", err_cnt - e0, 0);

        // Same token with bit0 of byte 1 flipped (addr 4): CRC error vs CRC ignored
        dev_addr = 7'h04;
        v0 = valid_cnt; e0 = err_cnt; n0 = nc_valid_cnt;
        pkt = '{8'hE1, 8'h04, token_b2(7'h05, 4'h2)};
        apply_stimulus();
        check_output("crc_err", tok_err, 1);
        check_output("crc_code", err_code, 2);
        check_output("crc_no_valid", tok_valid, 0);
        check_output("crc_hold_addr", tok_addr, 7'h05);
        check_output("nocrc_valid", nc_valid, 1);
        check_output("nocrc_addr", nc_addr, 7'h04);
        idle_cycles(1);
        check_output("crc_err_width", tok_err, 0);
        check_output("crc_counts", {valid_cnt - v0, err_cnt - e0, nc_valid_cnt - n0}, {32'd0, 32'd1, 32'd1});
        dev_addr = 7'h05;

        // 4-byte token: error one cycle after the 4th byte
        v0 = valid_cnt; e0 = err_cnt;
        rx_active = 1'b1;
        pkt = '{8'hE1, 8'h05, token_b2(7'h05, 4'h2), 8'h00};
        foreach (pkt[i]) begin
            rx_valid = 1'b1;
            rx_data  = pkt[i];
            @(posedge clk); #1;
            if (i == 2) check_output("len4_no_early_err", tok_err, 0);
        end
        rx_valid = 1'b0;
        check_output("len4_err", tok_err, 1);
        check_output("len4_code", err_code, 3);
        idle_cycles(1);
        rx_active = 1'b0;
        idle_cycles(2);
        check_output("len4_counts", {valid_cnt - v0, err_cnt - e0}, {32'd0, 32'd1});

        // Bad check nibble: error right after the PID byte, remainder ignored
        v0 = valid_cnt; e0 = err_cnt;
        rx_active = 1'b1; rx_valid = 1'b1; rx_data = 8'hE2;
        @(posedge clk); #1;
        check_output("pid_err", tok_err, 1);
        check_output("pid_code", err_code, 1);
        rx_data = 8'h05;
        @(posedge clk); #1;
        rx_data = token_b2(7'h05, 4'h2);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_active = 1'b0;
        idle_cycles(2);
        check_output("pid_counts", {valid_cnt - v0, err_cnt - e0}, {32'd0, 32'd1});
        check_output("pid_code_hold", err_code, 1);

        // SOF frame 0x7FF accepted regardless of address
        dev_addr = 7'h00;
        pkt = '{8'hA5, 8'hFF, token_b2(7'h7F, 4'hF)};
        apply_stimulus();
        check_output("sof_valid", tok_valid, 1);
        check_output("sof_pid", tok_pid, 4'h5);
        check_output("sof_frame", tok_frame, 11'h7FF);

        // SETUP to another device: silent
        dev_addr = 7'h05;
        idle_cycles(1);
        v0 = valid_cnt; e0 = err_cnt;
        pkt = '{8'h2D, 8'h06, token_b2(7'h06, 4'h0)};
        apply_stimulus();
        idle_cycles(2);
        check_output("setup_other_counts", {valid_cnt - v0, err_cnt - e0}, {32'd0, 32'd0});

        // 2-byte token: length error on the fall
        pkt = '{8'hE1, 8'h05};
        apply_stimulus();
        check_output("len2_err", tok_err, 1);
        check_output("len2_code", err_code, 3);
        idle_cycles(1);

        // DATA0 10 bytes plus stray rx_valid while inactive: nothing
        v0 = valid_cnt; e0 = err_cnt;
        pkt = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        apply_stimulus();
        rx_valid = 1'b1; rx_data = 8'hE1;
        idle_cycles(3);
        rx_valid = 1'b0;
        idle_cycles(2);
        check_output("data0_counts", {valid_cnt - v0, err_cnt - e0}, {32'd0, 32'd0});
        check_output("data0_code_hold", err_code, 3);

        // Reset during byte 1, then a good IN
        v0 = valid_cnt; e0 = err_cnt;
        rx_active = 1'b1; rx_valid = 1'b1; rx_data = 8'hE1;
        @(posedge clk); #1;
        rx_data = 8'h05; reset = 1'b1; rx_active = 1'b0; rx_valid = 1'b0;
        idle_cycles(2);
        check_output("rst_mid_code", err_code, 0);
        reset = 1'b0;
        idle_cycles(1);
        pkt = '{8'h69, 8'h85, token_b2(7'h05, 4'h1)};
        apply_stimulus();
        check_output("in_valid", tok_valid, 1);
        check_output("in_pid", tok_pid, 4'h9);
        check_output("in_endp", tok_endp, 4'h1);
        idle_cycles(2);
        check_output("rst_in_counts", {valid_cnt - v0, err_cnt - e0}, {32'd1, 32'd0});

        // Back-to-back IN tokens, next packet starts in the strobe cycle
        v0 = valid_cnt;
        pkt = '{8'h69, 8'h85, token_b2(7'h05, 4'h3)};
        apply_stimulus();
        check_output("b2b_first_endp", tok_endp, 4'h3);
        pkt = '{8'h69, 8'h05, token_b2(7'h05, 4'h4)};
        apply_stimulus();
        check_output("b2b_second_valid", tok_valid, 1);
        check_output("b2b_second_endp", tok_endp, 4'h4);
        idle_cycles(2);
        check_output("b2b_count", valid_cnt - v0, 2);

        // Hand-computed vector: OUT addr 0 endp 0, CRC byte 0x10
        dev_addr = 7'h00;
        pkt = '{8'hE1, 8'h00, 8'h10};
        apply_stimulus();
        check_output("hand_valid", tok_valid, 1);
        check_output("hand_frame", tok_frame, 11'h000);
        idle_cycles(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
